// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types for the parking gate controller: FSM states and service direction.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN_IN,
    OPEN_OUT,
    CLOSE
  } state_t;

  typedef enum logic {
    DIR_IN,
    DIR_OUT
  } dir_t;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Request/pass/status bundle between the vehicle side (master) and the gate controller (slave).
interface parking_gate_if #(
  parameter int CAPACITY = 99
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic             entry_req;
  logic             exit_req;
  logic             entry_pass;
  logic             exit_pass;
  logic             gate_open;
  logic             dir_in;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             violation;

  modport master (
    output entry_req, exit_req, entry_pass, exit_pass,
    input  gate_open, dir_in, inc, dec, occupancy, full, empty, violation
  );

  modport slave (
    input  entry_req, exit_req, entry_pass, exit_pass,
    output gate_open, dir_in, inc, dec, occupancy, full, empty, violation
  );
endinterface

// File: rtl/parking_gate_ctrl_gate_timer.sv
// Up-counter restarted by clear, which also latches the terminal count; done flags the terminal count.
module gate_timer #(
  parameter int MAX = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic [$clog2(MAX+1)-1:0]   limit,
  output logic                       done
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] limit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      limit_q <= limit;
    end else if (en && !done) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign done = (cnt_q == limit_q);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Shared barrier gate controller: round-robin entry/exit arbitration, open/close timing,
// occupancy mirror with full/empty flags, and inc/dec/violation pulses.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 99,
  parameter int OPEN_CYCLES  = 200_000_000,
  parameter int CLOSE_CYCLES = 100_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  parking_gate_if.slave bus
);
  localparam int CNT_W   = $clog2(CAPACITY + 1);
  localparam int TMR_MAX = ((OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES) - 1;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_LIM  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LIM = TMR_W'(CLOSE_CYCLES - 1);

  state_t           state_q;
  dir_t             last_dir_q;
  logic             gate_open_q, dir_in_q, inc_q, dec_q, violation_q;
  logic             full_q, empty_q;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;

  logic             entry_ok, exit_ok, take_in, take_out, leave_open, viol_d;
  logic             tmr_clear, tmr_en, tmr_done;
  logic [TMR_W-1:0] tmr_limit;

  always_comb begin
    entry_ok    = bus.entry_req && !full_q;
    exit_ok     = bus.exit_req && !empty_q;
    take_in     = (state_q == OPEN_IN) && bus.entry_pass;
    take_out    = (state_q == OPEN_OUT) && bus.exit_pass;
    occupancy_d = occupancy_q;
    if (take_in && occupancy_q != CAP_V)
      occupancy_d = occupancy_q + CNT_W'(1);
    else if (take_out && occupancy_q != '0)
      occupancy_d = occupancy_q - CNT_W'(1);
    // A pass wins over a simultaneous timeout or request drop; all three leave OPEN.
    leave_open = ((state_q == OPEN_IN) && (take_in || !bus.entry_req || tmr_done)) ||
                 ((state_q == OPEN_OUT) && (take_out || !bus.exit_req || tmr_done));
    unique case (state_q)
      OPEN_IN:  viol_d = bus.exit_pass;
      OPEN_OUT: viol_d = bus.entry_pass;
      default:  viol_d = bus.entry_pass || bus.exit_pass;
    endcase
    // IDLE keeps the timer primed with the open window so it starts at 0 on grant.
    tmr_clear = (state_q == IDLE) || leave_open;
    tmr_limit = (state_q == IDLE) ? OPEN_LIM : CLOSE_LIM;
    tmr_en    = (state_q != IDLE);
  end

  gate_timer #(.MAX(TMR_MAX)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_dir_q  <= DIR_IN;
      gate_open_q <= 1'b0;
      dir_in_q    <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      violation_q <= 1'b0;
      occupancy_q <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      inc_q       <= take_in && (occupancy_q != CAP_V);
      dec_q       <= take_out && (occupancy_q != '0);
      violation_q <= viol_d;
      occupancy_q <= occupancy_d;
      full_q      <= (occupancy_d == CAP_V);
      empty_q     <= (occupancy_d == '0);
      unique case (state_q)
        IDLE: begin
          if (entry_ok && (!exit_ok || last_dir_q == DIR_OUT)) begin
            state_q     <= OPEN_IN;
            gate_open_q <= 1'b1;
            dir_in_q    <= 1'b1;
          end else if (exit_ok) begin
            state_q     <= OPEN_OUT;
            gate_open_q <= 1'b1;
            dir_in_q    <= 1'b0;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (leave_open) begin
            state_q     <= CLOSE;
            gate_open_q <= 1'b0;
            if (take_in)  last_dir_q <= DIR_IN;
            if (take_out) last_dir_q <= DIR_OUT;
          end
        end
        CLOSE: begin
          if (tmr_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gate_open = gate_open_q;
  assign bus.dir_in    = dir_in_q;
  assign bus.inc       = inc_q;
  assign bus.dec       = dec_q;
  assign bus.occupancy = occupancy_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.violation = violation_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a scoreboard queue holds expected inc/dec/violation events.
module tb_parking_gate_ctrl;
  localparam int CAP   = 3;
  localparam int OPENC = 8;
  localparam int CLOSC = 2;

  localparam logic [2:0] K_INC  = 3'b100;
  localparam logic [2:0] K_DEC  = 3'b010;
  localparam logic [2:0] K_VIOL = 3'b001;

  typedef struct {
    string      tag;
    logic [2:0] kind;
    int         occ;
  } evt_t;

  logic clk;
  logic reset_n;

  parking_gate_if #(.CAPACITY(CAP)) bus ();

  parking_gate_ctrl #(
    .CAPACITY     (CAP),
    .OPEN_CYCLES  (OPENC),
    .CLOSE_CYCLES (CLOSC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  evt_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   run = 0, zrun = 0, last_len = 0, last_gap = 0, opens = 0, viols = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input logic [2:0] kind, input int occ);
    evt_t e;
    e.tag = tag; e.kind = kind; e.occ = occ;
    sb.push_back(e);
  endtask

  // One clock step: returns at the falling edge and scores any pulse seen there.
  task automatic cyc();
    evt_t e;
    logic [2:0] seen;
    @(negedge clk);
    seen = {bus.inc, bus.dec, bus.violation};
    if (bus.gate_open) begin
      if (zrun > 0) begin last_gap = zrun; opens++; end
      zrun = 0;
      run++;
    end else begin
      if (run > 0) last_len = run;
      run = 0;
      zrun++;
    end
    if (bus.violation) viols++;
    if (seen != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(seen), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_kind"}, 32'(seen), 32'(e.kind));
        chk({e.tag, "_occ"}, 32'(bus.occupancy), 32'(e.occ));
        $display("txn %s: pulses inc/dec/viol=%b occupancy=%0d", e.tag, seen, bus.occupancy);
      end
    end
  endtask

  task automatic pulse(input bit is_entry, input string tag);
    if (is_entry) bus.entry_pass = 1'b1; else bus.exit_pass = 1'b1;
    cyc();
    bus.entry_pass = 1'b0;
    bus.exit_pass  = 1'b0;
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_gate(input string tag, input logic lvl, input int budget);
    int k = 0;
    while (bus.gate_open !== lvl && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, 32'(bus.gate_open), 32'(lvl));
  endtask

  initial begin
    int base;
    reset_n        = 1'b0;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.entry_pass = 1'b0;
    bus.exit_pass  = 1'b0;
    repeat (3) cyc();
    chk("rst_gate_open", 32'(bus.gate_open), 32'd0);
    chk("rst_dir_in",    32'(bus.dir_in),    32'd0);
    chk("rst_inc",       32'(bus.inc),       32'd0);
    chk("rst_dec",       32'(bus.dec),       32'd0);
    chk("rst_occ",       32'(bus.occupancy), 32'd0);
    chk("rst_full",      32'(bus.full),      32'd0);
    chk("rst_empty",     32'(bus.empty),     32'd1);
    chk("rst_viol",      32'(bus.violation), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Single entry: pass in the 3rd open cycle.
    bus.entry_req = 1'b1;
    cyc();
    chk("entry_grant_open", 32'(bus.gate_open), 32'd1);
    chk("entry_grant_dir",  32'(bus.dir_in),    32'd1);
    cyc();
    cyc();
    expect_evt("entry1", K_INC, 1);
    pulse(1'b1, "entry1");
    chk("entry1_open_len", 32'(last_len), 32'd3);
    chk("entry1_gate_low", 32'(bus.gate_open), 32'd0);
    chk("entry1_empty",    32'(bus.empty), 32'd0);
    wait_gate("reopen", 1'b1, 10);
    chk("close_gap", 32'(last_gap), 32'(CLOSC + 1));
    bus.entry_req = 1'b0;
    cyc();
    chk("req_drop_close", 32'(bus.gate_open), 32'd0);
    chk("req_drop_occ",   32'(bus.occupancy), 32'd1);
    repeat (4) cyc();

    // Exit timeout at occupancy 1.
    bus.exit_req = 1'b1;
    cyc();
    chk("exit_grant_open", 32'(bus.gate_open), 32'd1);
    chk("exit_grant_dir",  32'(bus.dir_in),    32'd0);
    wait_gate("timeout_close", 1'b0, 20);
    chk("timeout_len", 32'(last_len), 32'(OPENC));
    chk("timeout_occ", 32'(bus.occupancy), 32'd1);
    bus.exit_req = 1'b0;
    repeat (4) cyc();

    // Tie arbitration: exit, entry, exit, entry.
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gate($sformatf("tie%0d_open", i), 1'b1, 10);
      chk($sformatf("tie%0d_dir", i), 32'(bus.dir_in), 32'((i % 2 == 1) ? 1 : 0));
      if (i % 2 == 0) begin
        expect_evt($sformatf("tie%0d", i), K_DEC, 0);
        pulse(1'b0, $sformatf("tie%0d", i));
      end else begin
        expect_evt($sformatf("tie%0d", i), K_INC, 1);
        pulse(1'b1, $sformatf("tie%0d", i));
      end
    end
    chk("tie_occ", 32'(bus.occupancy), 32'd1);
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    repeat (4) cyc();

    // Fill to capacity, then entry must be refused.
    bus.entry_req = 1'b1;
    for (int i = 2; i <= CAP; i++) begin
      wait_gate($sformatf("fill%0d_open", i), 1'b1, 10);
      expect_evt($sformatf("fill%0d", i), K_INC, i);
      pulse(1'b1, $sformatf("fill%0d", i));
    end
    chk("full_flag", 32'(bus.full), 32'd1);
    base = opens;
    repeat (15) cyc();
    chk("full_refused", 32'(opens), 32'(base));
    bus.entry_req = 1'b0;

    // Drain to empty, then exit must be ignored.
    bus.exit_req = 1'b1;
    for (int i = CAP - 1; i >= 0; i--) begin
      wait_gate($sformatf("drain%0d_open", i), 1'b1, 10);
      expect_evt($sformatf("drain%0d", i), K_DEC, i);
      pulse(1'b0, $sformatf("drain%0d", i));
    end
    chk("empty_flag", 32'(bus.empty), 32'd1);
    chk("empty_full", 32'(bus.full), 32'd0);
    base = opens;
    repeat (15) cyc();
    chk("empty_refused", 32'(opens), 32'(base));
    bus.exit_req = 1'b0;

    // Violations: in IDLE, opposite direction while open, and during CLOSE.
    base = viols;
    expect_evt("viol_idle", K_VIOL, 0);
    pulse(1'b1, "viol_idle");
    bus.entry_req = 1'b1;
    wait_gate("viol_open", 1'b1, 10);
    expect_evt("viol_opp", K_VIOL, 0);
    pulse(1'b0, "viol_opp");
    chk("viol_still_open", 32'(bus.gate_open), 32'd1);
    bus.entry_req = 1'b0;
    cyc();
    expect_evt("viol_close", K_VIOL, 0);
    pulse(1'b0, "viol_close");
    chk("viol_count", 32'(viols - base), 32'd3);
    chk("viol_occ", 32'(bus.occupancy), 32'd0);
    repeat (4) cyc();

    // Pass sampled on the timeout edge is still counted.
    bus.entry_req = 1'b1;
    cyc();
    repeat (7) cyc();
    expect_evt("pass_at_timeout", K_INC, 1);
    pulse(1'b1, "pass_at_timeout");
    chk("timeout_pass_len", 32'(last_len), 32'(OPENC));
    chk("timeout_pass_occ", 32'(bus.occupancy), 32'd1);

    // Reach occupancy 2, reopen for entry, then reset asynchronously mid-open.
    wait_gate("occ2_open", 1'b1, 10);
    expect_evt("occ2", K_INC, 2);
    pulse(1'b1, "occ2");
    wait_gate("arst_open", 1'b1, 10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_gate", 32'(bus.gate_open), 32'd0);
    chk("arst_occ",  32'(bus.occupancy), 32'd0);
    chk("arst_full", 32'(bus.full),      32'd0);
    chk("arst_empty", 32'(bus.empty),    32'd1);
    bus.entry_req = 1'b0;
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
